// File: rtl/zet_wb_switch_pkg.sv
// Shared types and helpers for the zet Wishbone switch: FSM state and
// transaction-kind encodings, fixed response data, and the window matcher.
package zet_wb_switch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    KIND_SLAVE = 2'd0,
    KIND_NONE  = 2'd1,
    KIND_INTA  = 2'd2
  } kind_e;

  localparam logic [15:0] DAT_UNMAPPED = 16'h0000;
  localparam logic [15:0] DAT_TIMEOUT  = 16'hFFFF;

  // A window matches when every masked bit agrees; an all-zero mask means the
  // window does not exist at all (rather than matching everything).
  function automatic logic win_match(input logic [14:0] field,
                                     input logic [14:0] base,
                                     input logic [14:0] mask);
    return (mask != '0) && (((field ^ base) & mask) == '0);
  endfunction

endpackage

// File: rtl/zet_wb_switch_decoder.sv
// Address decoder: matches the current address against each slave's memory
// or I/O window (selected by tga) and returns a lowest-index-wins one-hot hit.
module zet_wb_switch_decoder
  import zet_wb_switch_pkg::*;
#(
  parameter int               NS       = 4,
  parameter logic [NS*8-1:0]  MEM_BASE = '0,
  parameter logic [NS*8-1:0]  MEM_MASK = '0,
  parameter logic [NS*15-1:0] IO_BASE  = '0,
  parameter logic [NS*15-1:0] IO_MASK  = '0
) (
  input  logic [19:1]   adr,
  input  logic          tga,
  output logic [NS-1:0] hit,
  output logic          any_hit
);

  logic [NS-1:0] raw;

  // Raw per-slave window match; memory uses adr[19:12], I/O uses adr[15:1].
  always_comb begin
    raw = '0;
    for (int k = 0; k < NS; k++) begin
      if (tga)
        raw[k] = win_match(adr[15:1], IO_BASE[k*15 +: 15], IO_MASK[k*15 +: 15]);
      else
        raw[k] = win_match({7'b0, adr[19:12]}, {7'b0, MEM_BASE[k*8 +: 8]},
                           {7'b0, MEM_MASK[k*8 +: 8]});
    end
  end

  // Priority pick: scanning downwards leaves the lowest matching index set.
  always_comb begin
    hit = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (raw[k]) begin
        hit    = '0;
        hit[k] = 1'b1;
      end
    end
    any_hit = |raw;
  end

endmodule

// File: rtl/zet_wb_switch.sv
// Single-master, NS-slave Wishbone switch: decodes each cycle to a slave, an
// interrupt-acknowledge vector or the unmapped responder, routes stb/ack/data,
// and forces an error ack if a granted slave stalls past TIMEOUT cycles.
module zet_wb_switch
  import zet_wb_switch_pkg::*;
#(
  parameter int               NS       = 4,
  parameter logic [NS*8-1:0]  MEM_BASE = 32'h00_C0_00_B8,
  parameter logic [NS*8-1:0]  MEM_MASK = 32'h00_F0_00_FF,
  parameter logic [NS*15-1:0] IO_BASE  = {15'h00F8, 15'h0038, 15'h0030, 15'h0000},
  parameter logic [NS*15-1:0] IO_MASK  = {15'h7FF8, 15'h7FF0, 15'h7FFC, 15'h0000},
  parameter logic [15:0]      INT_VEC  = 16'd9,
  parameter int               TIMEOUT  = 255,
  parameter int               TW       = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [15:0]      m_dat_i,
  output logic [15:0]      m_dat_o,
  input  logic [19:1]      m_adr_i,
  input  logic             m_we_i,
  input  logic             m_tga_i,
  input  logic             m_stb_i,
  input  logic             m_cyc_i,
  input  logic [1:0]       m_sel_i,
  input  logic             m_tgc_i,
  output logic             m_ack_o,
  output logic             m_err_o,
  input  logic [NS*16-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  output logic [NS-1:0]    s_stb_o,
  output logic [19:1]      s_adr_o,
  output logic [15:0]      s_dat_o,
  output logic             s_we_o,
  output logic [1:0]       s_sel_o,
  output logic             s_tga_o
);

  localparam bit            WD_ON   = (TIMEOUT != 0);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_e        state, state_nxt;
  kind_e         kind, kind_nxt;
  logic [NS-1:0] grant, grant_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [NS-1:0] hit;
  logic          any_hit;
  logic          slave_ack;
  logic [15:0]   slave_dat;
  logic          live;

  // Address, data and qualifiers reach every slave unregistered; only stb is routed.
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_we_o  = m_we_i;
  assign s_sel_o = m_sel_i;
  assign s_tga_o = m_tga_i;
  assign live    = m_stb_i & m_cyc_i;

  zet_wb_switch_decoder #(
    .NS       (NS),
    .MEM_BASE (MEM_BASE),
    .MEM_MASK (MEM_MASK),
    .IO_BASE  (IO_BASE),
    .IO_MASK  (IO_MASK)
  ) u_decoder (
    .adr     (m_adr_i),
    .tga     (m_tga_i),
    .hit     (hit),
    .any_hit (any_hit)
  );

  // Granted slave's ack and read data (grant is one-hot or zero).
  always_comb begin
    slave_ack = |(s_ack_i & grant);
    slave_dat = '0;
    for (int k = 0; k < NS; k++) begin
      if (grant[k]) slave_dat = s_dat_i[k*16 +: 16];
    end
  end

  // Next-state, grant, watchdog and master/slave response logic.
  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    s_stb_o   = '0;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_dat_o   = DAT_UNMAPPED;
    case (state)
      ST_IDLE: begin
        if (live) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = '0;
          if (m_tgc_i) begin
            kind_nxt  = KIND_INTA;
            grant_nxt = '0;
          end else if (any_hit) begin
            kind_nxt  = KIND_SLAVE;
            grant_nxt = hit;
          end else begin
            kind_nxt  = KIND_NONE;
            grant_nxt = '0;
          end
        end
      end
      ST_BUSY: begin
        if (!m_cyc_i) begin
          // Master abandoned the cycle: drop everything, no ack.
          state_nxt = ST_IDLE;
        end else begin
          case (kind)
            KIND_SLAVE: begin
              s_stb_o = grant & {NS{m_stb_i}};
              if (slave_ack) begin
                m_ack_o = 1'b1;
                m_dat_o = slave_dat;
              end else if (WD_ON && cnt == WD_LAST) begin
                m_ack_o = 1'b1;
                m_err_o = 1'b1;
                m_dat_o = DAT_TIMEOUT;
              end else if (cnt != '1) begin
                cnt_nxt = cnt + 1'b1;
              end
            end
            KIND_INTA: begin
              m_ack_o = 1'b1;
              m_dat_o = INT_VEC;
            end
            default: begin
              m_ack_o = 1'b1;
              m_dat_o = DAT_UNMAPPED;
            end
          endcase
          if (m_ack_o) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A transaction caught by reset is dropped without any response.
    if (wb_rst_i) begin
      m_ack_o = 1'b0;
      m_err_o = 1'b0;
      m_dat_o = DAT_UNMAPPED;
    end
  end

  // State, kind, grant and watchdog registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      kind  <= KIND_NONE;
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      kind  <= kind_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
